// File: rtl/overvoltage_pkg.sv
// Shared types and helpers for the over-voltage detector controller.
package overvoltage_pkg;

  localparam int OV_TRIP_W = 4;
  localparam int OV_TAPS   = 2**OV_TRIP_W;

  typedef enum logic [1:0] {
    ST_OFF     = 2'd0,
    ST_SETTLE  = 2'd1,
    ST_MONITOR = 2'd2
  } ov_state_e;

  function automatic logic [OV_TAPS-1:0] onehot_decode(input logic [OV_TRIP_W-1:0] code);
    logic [OV_TAPS-1:0] v;
    v       = '0;
    v[code] = 1'b1;
    return v;
  endfunction

endpackage

// File: rtl/overvoltage_ctrl_debounce.sv
// Synchronizer plus debounce filter producing the clean over-voltage level.
module ov_debounce #(
  parameter int DEBOUNCE_CYCLES = 8
) (
  input  logic clk,
  input  logic rst,
  input  logic clr_i,
  input  logic run_i,
  input  logic async_i,
  output logic level_o
);

  localparam int CNT_W = $clog2(DEBOUNCE_CYCLES + 1);

  logic             sync1_q, sync2_q;
  logic             level_q, level_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  // The count only advances while the synchronized input disagrees with the
  // published level; any agreement restarts the window.
  always_comb begin
    level_d = level_q;
    cnt_d   = '0;
    if (clr_i) begin
      level_d = 1'b0;
    end else if (run_i && (sync2_q != level_q)) begin
      if (cnt_q == CNT_W'(DEBOUNCE_CYCLES - 1)) begin
        level_d = sync2_q;
      end else begin
        cnt_d = cnt_q + CNT_W'(1);
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
      level_q <= 1'b0;
      cnt_q   <= '0;
    end else begin
      sync1_q <= async_i;
      sync2_q <= sync1_q;
      level_q <= level_d;
      cnt_q   <= cnt_d;
    end
  end

  assign level_o = level_q;

endmodule

// File: rtl/overvoltage_ctrl.sv
// Over-voltage detector controller: enable/settle FSM, trip decode, debounced
// flag with irq/sticky. Define OV_HYST_EN to lower the trip code while ov_o=1.
module overvoltage_ctrl
  import overvoltage_pkg::*;
#(
  parameter int TRIP_W          = OV_TRIP_W,
  parameter int SETTLE_CYCLES   = 64,
  parameter int DEBOUNCE_CYCLES = 8,
  parameter int HYST_STEPS      = 1
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 en_i,
  input  logic [TRIP_W-1:0]    otrip_i,
  input  logic                 isrc_sel_i,
  input  logic                 sticky_clr_i,
  input  logic                 ovout_i,
  output logic                 ena_o,
  output logic                 isrc_sel_o,
  output logic [2**TRIP_W-1:0] otrip_decoded_o,
  output logic                 ov_valid_o,
  output logic                 ov_o,
  output logic                 ov_irq_o,
  output logic                 ov_sticky_o,
  output ov_state_e            state_o
);

  localparam int SET_W = $clog2(SETTLE_CYCLES + 1);

`ifdef OV_HYST_EN
  localparam bit HYST_ON = 1'b1;
`else
  localparam bit HYST_ON = 1'b0;
`endif

  ov_state_e             state_q, state_d;
  logic [SET_W-1:0]      settle_q, settle_d;
  logic [TRIP_W-1:0]     code_q, code_d, code_eff_d;
  logic [2**TRIP_W-1:0]  dec_q, dec_d;
  logic                  isrc_q;
  logic                  ov_w, ov_prev_q, rise_w;
  logic                  sticky_q, sticky_d;

  always_comb begin
    state_d  = state_q;
    code_d   = code_q;
    settle_d = settle_q;
    case (state_q)
      ST_OFF: begin
        if (en_i) begin
          state_d  = ST_SETTLE;
          code_d   = otrip_i;
          settle_d = '0;
        end
      end
      ST_SETTLE, ST_MONITOR: begin
        if (otrip_i != code_q) begin
          state_d  = ST_SETTLE;
          code_d   = otrip_i;
          settle_d = '0;
        end else if (state_q == ST_SETTLE) begin
          if (settle_q == SET_W'(SETTLE_CYCLES - 1)) begin
            state_d  = ST_MONITOR;
            settle_d = '0;
          end else begin
            settle_d = settle_q + SET_W'(1);
          end
        end
      end
      default: state_d = ST_OFF;
    endcase
    if (!en_i) begin
      state_d  = ST_OFF;
      settle_d = '0;
    end
  end

  // Hysteresis follows the current flag; it never touches code_q, so it
  // cannot trigger a settle restart.
  always_comb begin
    code_eff_d = code_d;
    if (HYST_ON && ov_w) begin
      if (int'(code_d) > HYST_STEPS) code_eff_d = code_d - TRIP_W'(HYST_STEPS);
      else                           code_eff_d = '0;
    end
  end

  assign dec_d    = (state_d != ST_OFF) ? onehot_decode(code_eff_d) : '0;
  assign rise_w   = ov_w & ~ov_prev_q;
  assign sticky_d = rise_w ? 1'b1 : (sticky_clr_i ? 1'b0 : sticky_q);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= ST_OFF;
      settle_q  <= '0;
      code_q    <= '0;
      dec_q     <= '0;
      isrc_q    <= 1'b0;
      ov_prev_q <= 1'b0;
      sticky_q  <= 1'b0;
    end else begin
      state_q   <= state_d;
      settle_q  <= settle_d;
      code_q    <= code_d;
      dec_q     <= dec_d;
      isrc_q    <= isrc_sel_i;
      ov_prev_q <= ov_w;
      sticky_q  <= sticky_d;
    end
  end

  ov_debounce #(
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
  ) u_debounce (
    .clk     (clk),
    .rst     (rst),
    .clr_i   (~en_i),
    .run_i   (state_q == ST_MONITOR),
    .async_i (ovout_i),
    .level_o (ov_w)
  );

  assign ena_o           = (state_q != ST_OFF);
  assign ov_valid_o      = (state_q == ST_MONITOR);
  assign otrip_decoded_o = dec_q;
  assign isrc_sel_o      = isrc_q;
  assign ov_o            = ov_w;
  assign ov_irq_o        = rise_w;
  assign ov_sticky_o     = sticky_q;
  assign state_o         = state_q;

endmodule

// File: tb/tb_overvoltage_ctrl.sv
// Self-checking bench for overvoltage_ctrl: vector table, corner sequences,
// and randomized traffic against a behavioural reference model.
module tb_overvoltage_ctrl;
  import overvoltage_pkg::*;

  localparam int NTAP   = 16;
  localparam int SETTLE = 64;
  localparam int DEB    = 8;
  localparam int HYST   = 1;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic en_i = 1'b0, isrc_sel_i = 1'b0, sticky_clr_i = 1'b0, ovout_i = 1'b0;
  logic [3:0] otrip_i = '0;
  logic ena_o, isrc_sel_o, ov_valid_o, ov_o, ov_irq_o, ov_sticky_o;
  logic [NTAP-1:0] otrip_decoded_o;
  ov_state_e state_o;

  always #5 clk = ~clk;

  overvoltage_ctrl dut (
    .clk             (clk),
    .rst             (rst),
    .en_i            (en_i),
    .otrip_i         (otrip_i),
    .isrc_sel_i      (isrc_sel_i),
    .sticky_clr_i    (sticky_clr_i),
    .ovout_i         (ovout_i),
    .ena_o           (ena_o),
    .isrc_sel_o      (isrc_sel_o),
    .otrip_decoded_o (otrip_decoded_o),
    .ov_valid_o      (ov_valid_o),
    .ov_o            (ov_o),
    .ov_irq_o        (ov_irq_o),
    .ov_sticky_o     (ov_sticky_o),
    .state_o         (state_o)
  );

  int errors = 0;
  int checks = 0;

  // Reference model: block status, settle time remaining, raw sample history
  // and the run of consecutive disagreeing monitor clocks.
  bit         m_on, m_mon, m_ov, m_prev, m_sticky, m_isrc;
  int         m_left;
  logic [3:0] m_code;
  logic [NTAP-1:0] m_dec;
  bit         smp_q[$];
  bit         win_q[$];

  function automatic logic [21:0] dut_vec();
    return {ena_o, ov_valid_o, ov_o, ov_irq_o, ov_sticky_o, isrc_sel_o, otrip_decoded_o};
  endfunction

  function automatic logic [21:0] model_vec();
    return {m_on, m_mon, m_ov, (m_ov && !m_prev), m_sticky, m_isrc, m_dec};
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_edge();
    bit syncv, ov_before, mon_before;
    int ce;
    syncv      = (smp_q.size() >= 2) ? smp_q[0] : 1'b0;
    ov_before  = m_ov;
    mon_before = m_mon;
    if (m_ov && !m_prev) m_sticky = 1'b1;
    else if (sticky_clr_i) m_sticky = 1'b0;
    m_prev = m_ov;
    if (!en_i) begin
      m_ov = 1'b0;
      win_q.delete();
    end else if (mon_before && (syncv != m_ov)) begin
      win_q.push_back(1'b1);
      if (win_q.size() == DEB) begin
        m_ov = syncv;
        win_q.delete();
      end
    end else begin
      win_q.delete();
    end
    if (!en_i) begin
      m_on  = 1'b0;
      m_mon = 1'b0;
    end else if (!m_on || (otrip_i != m_code)) begin
      m_on   = 1'b1;
      m_mon  = 1'b0;
      m_code = otrip_i;
      m_left = SETTLE;
    end else if (!m_mon) begin
      m_left--;
      if (m_left == 0) m_mon = 1'b1;
    end
    smp_q.push_back(ovout_i);
    if (smp_q.size() > 2) void'(smp_q.pop_front());
    ce = int'(m_code);
`ifdef OV_HYST_EN
    if (ov_before) ce = (ce > HYST) ? ce - HYST : 0;
`else
    if (ov_before && HYST < 0) ce = 0;
`endif
    m_dec  = m_on ? (NTAP'(1) << ce) : '0;
    m_isrc = isrc_sel_i;
  endtask

  task automatic step();
    model_edge();
    @(posedge clk);
    #1;
    check("model", dut_vec(), model_vec());
  endtask

  typedef struct {
    string      name;
    logic       en;
    logic [3:0] otrip;
    logic       isrc;
    logic       ovout;
    int         n;
    logic       e_ena, e_valid, e_ov, e_sticky;
    logic [NTAP-1:0] e_dec;
  } vec_t;

  localparam int NV = 11;
  vec_t tbl[NV];

  task automatic set_row(input int i, input string nm, input logic en, input logic [3:0] ot,
                         input logic is, input logic ovo, input int n, input logic ea,
                         input logic ev, input logic eo, input logic es, input logic [NTAP-1:0] ed);
    tbl[i] = '{nm, en, ot, is, ovo, n, ea, ev, eo, es, ed};
  endtask

  initial begin
    int lat, irqs, hold_left;
    bit found;

    set_row(0,  "idle",       1'b0, 4'd0, 1'b1, 1'b0, 2,  1'b0, 1'b0, 1'b0, 1'b0, 16'h0000);
    set_row(1,  "enable",     1'b1, 4'd5, 1'b0, 1'b0, 1,  1'b1, 1'b0, 1'b0, 1'b0, 16'h0020);
    set_row(2,  "settle63",   1'b1, 4'd5, 1'b1, 1'b0, 63, 1'b1, 1'b0, 1'b0, 1'b0, 16'h0020);
    set_row(3,  "valid64",    1'b1, 4'd5, 1'b0, 1'b0, 1,  1'b1, 1'b1, 1'b0, 1'b0, 16'h0020);
    set_row(4,  "glitch5",    1'b1, 4'd5, 1'b0, 1'b1, 5,  1'b1, 1'b1, 1'b0, 1'b0, 16'h0020);
    set_row(5,  "glitch_end", 1'b1, 4'd5, 1'b1, 1'b0, 12, 1'b1, 1'b1, 1'b0, 1'b0, 16'h0020);
    set_row(6,  "retrip",     1'b1, 4'd9, 1'b1, 1'b0, 1,  1'b1, 1'b0, 1'b0, 1'b0, 16'h0200);
    set_row(7,  "resettle63", 1'b1, 4'd9, 1'b0, 1'b0, 63, 1'b1, 1'b0, 1'b0, 1'b0, 16'h0200);
    set_row(8,  "revalid64",  1'b1, 4'd9, 1'b0, 1'b0, 1,  1'b1, 1'b1, 1'b0, 1'b0, 16'h0200);
    set_row(9,  "disable",    1'b0, 4'd9, 1'b1, 1'b0, 1,  1'b0, 1'b0, 1'b0, 1'b0, 16'h0000);
    set_row(10, "reenable",   1'b1, 4'd9, 1'b0, 1'b0, 65, 1'b1, 1'b1, 1'b0, 1'b0, 16'h0200);

    // Clock/reset
    repeat (2) @(posedge clk);
    #1;
    check("reset_outputs", dut_vec(), 32'h0);
    check("reset_state", state_o, ST_OFF);
    rst = 1'b0;

    // Vector table
    for (int r = 0; r < NV; r++) begin
      en_i       = tbl[r].en;
      otrip_i    = tbl[r].otrip;
      isrc_sel_i = tbl[r].isrc;
      ovout_i    = tbl[r].ovout;
      for (int k = 0; k < tbl[r].n; k++) step();
      check(tbl[r].name, dut_vec(), {tbl[r].e_ena, tbl[r].e_valid, tbl[r].e_ov, 1'b0,
                                     tbl[r].e_sticky, tbl[r].isrc, tbl[r].e_dec});
    end

    // Debounce latency, single irq, sticky set
    ovout_i = 1'b1;
    lat = 0;
    irqs = 0;
    for (int i = 0; i < 20; i++) begin
      step();
      if (ov_o && lat == 0) lat = i + 1;
      if (ov_irq_o) irqs++;
    end
    check("latency_10_11", (lat >= 10 && lat <= 11), 1);
    check("irq_count", irqs, 1);
    check("sticky_set", ov_sticky_o, 1);

    // Disable drops everything except sticky
    en_i = 1'b0;
    step();
    check("off_outputs", {ena_o, ov_o, ov_valid_o, otrip_decoded_o}, 0);
    check("off_sticky_kept", ov_sticky_o, 1);
    ovout_i = 1'b0;
    en_i = 1'b1;
    for (int i = 0; i < SETTLE + 1; i++) step();
    check("revalid_after_off", ov_valid_o, 1);

    // Sticky clear alone, then clear colliding with a new rise
    sticky_clr_i = 1'b1;
    step();
    sticky_clr_i = 1'b0;
    check("sticky_clear", ov_sticky_o, 0);
    ovout_i = 1'b1;
    found = 1'b0;
    for (int i = 0; i < 20 && !found; i++) begin
      step();
      if (ov_irq_o) found = 1'b1;
    end
    check("rise_seen", found, 1);
    sticky_clr_i = 1'b1;
    step();
    sticky_clr_i = 1'b0;
    check("set_beats_clear", ov_sticky_o, 1);
    check("irq_one_cycle", ov_irq_o, 0);
    sticky_clr_i = 1'b1;
    step();
    sticky_clr_i = 1'b0;
    check("sticky_clear2", ov_sticky_o, 0);

`ifdef OV_HYST_EN
    otrip_i = 4'd0;
    step();
    check("hyst_saturate", otrip_decoded_o, 16'h0001);
    otrip_i = 4'd5;
    step();
    check("hyst_lowered", otrip_decoded_o, 16'h0010);
    for (int i = 0; i < SETTLE; i++) step();
    check("hyst_monitor", {ov_valid_o, ov_o, otrip_decoded_o}, {2'b11, 16'h0010});
`endif

    // Randomized traffic against the reference model
    hold_left = 0;
    for (int c = 0; c < 3000; c++) begin
      en_i = ($urandom_range(0, 299) != 0);
      if ($urandom_range(0, 199) == 0) otrip_i = 4'($urandom_range(0, 15));
      if (hold_left == 0) begin
        ovout_i   = 1'($urandom_range(0, 1));
        hold_left = $urandom_range(1, 20);
      end else begin
        hold_left--;
      end
      sticky_clr_i = ($urandom_range(0, 19) == 0);
      isrc_sel_i   = 1'($urandom_range(0, 1));
      step();
    end
    sticky_clr_i = 1'b0;

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
